instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction fetch stage placed directly upstream of the single-cycle datapath. Owns the fetch program counter, reads instruction memory through a valid/ack handshake, and buffers fetched instructions with their PCs in a small FIFO. Decode/execute drains the FIFO through a valid/ready handshake, which decouples memory stalls from datapath stalls. A redirect input, driven by branch/jump resolution, flushes the FIFO and restarts fetch at a new address.

## Interface
- ADDR_W, 16, width of program counter and instruction address
- INSN_W, 64, instruction word width
- DEPTH, 4, FIFO entries; power of two, >= 2
- PC_STEP, 4, byte increment between sequential fetches
- RESET_PC, 16'd0, fetch address after reset
- clk  input  1  single clock; all state updates on its rising edge
- rst  input  1  synchronous, active-high reset
- mem_req  output  1  fetch request to instruction memory
- mem_adr  output  ADDR_W  fetch address; equals fetch_pc
- mem_ack  input  1  memory accepts request; mem_rdata valid in the same cycle
- mem_rdata  input  INSN_W  instruction word for mem_adr
- redirect  input  1  flush and restart fetch at redirect_pc
- redirect_pc  input  ADDR_W  new fetch address; bits [1:0] forced to 0 internally
- insn_valid  output  1  head FIFO entry presented
- insn_ready  input  1  consumer takes head entry
- insn  output  INSN_W  head instruction; 0 when insn_valid=0
- insn_pc  output  ADDR_W  address of head instruction; 0 when insn_valid=0
- count  output  $clog2(DEPTH)+1  number of occupied FIFO entries

## Operation
- State: fetch_pc register, FIFO storage of {pc, insn} × DEPTH, write pointer, read pointer, occupancy count.
- mem_req = !rst && !redirect && (count < DEPTH). It never depends on insn_ready, so there is no combinational ready-to-request path.
- mem_adr = fetch_pc at all times, including when mem_req=0.
- Push happens on mem_req && mem_ack. The block writes {fetch_pc, mem_rdata} at the write pointer, advances the write pointer, and sets fetch_pc to fetch_pc + PC_STEP modulo 2^ADDR_W. 16'hFFFC wraps to 16'h0000.
- insn_valid = (count != 0) && !redirect.
- Pop happens on insn_valid && insn_ready and advances the read pointer.
- Push and pop in the same cycle leave count unchanged. When full, there is no push even if a pop occurs that cycle; the request reissues the next cycle.
- Redirect has priority over everything:
  - count, read pointer and write pointer go to 0.
  - fetch_pc <= {redirect_pc[ADDR_W-1:2], 2'b00}.
  - No push or pop occurs that cycle. mem_req and insn_valid are 0.
- Pointers wrap modulo DEPTH. count ranges 0..DEPTH and never over- or underflows.
- Memory ack without req is ignored.
- Reset:
  - fetch_pc=RESET_PC, pointers=0, count=0.
  - Outputs during and after the reset cycle: mem_req=0, mem_adr=RESET_PC, insn_valid=0, insn=0, insn_pc=0, count=0.
  - FIFO storage is not reset.
  - rst asserted mid-operation discards all buffered entries and any same-cycle handshake.

## Timing
- Fetch latency: request accepted in cycle N, entry visible at insn_valid/insn in cycle N+1.
- First fetch: rst deasserted before edge E; mem_req=1 in the cycle after E. With immediate ack, insn_valid=1 one cycle later.
- Throughput: 1 instruction/cycle while mem_ack=1 and insn_ready=1 steadily; count holds at 1.
- Redirect asserted in cycle N: mem_adr shows the new target in N+1, mem_req=1 in N+1, the first new instruction is valid in N+2.
- insn, insn_pc and insn_valid are driven from registered state. The only combinational inputs to insn_valid and mem_req are redirect and rst.
- Back-pressure: with insn_ready=0 and mem_ack=1, count reaches DEPTH after DEPTH accepted requests. mem_req drops the cycle count==DEPTH.

## Test plan
- Reset then mem_ack=1, insn_ready=1: mem_adr sequence 0,4,8,12…; insn_pc matches 0,4,8 one cycle later; insn equals the memory model's word for each address.
- insn_ready=0, mem_ack=1 from reset: count goes 1,2,3,4; mem_req=0 at count=4. Raising insn_ready drains entries in order with pcs 0,4,8,12, then fetching resumes at 16.
- Redirect to 16'h0102 while count=3: the next cycle has count=0, insn_valid=0, mem_adr=16'h0100. The first valid instruction after that has insn_pc=16'h0100, and no stale entry is ever presented.
- Wrap: redirect to 16'hFFF8 with steady ack: insn_pc sequence FFF8, FFFC, 0000, 0004.
- Random mem_ack/insn_ready (50%) over 2000 cycles against a scoreboard: in-order, no loss or duplication, count always equals pushes minus pops and stays within 0..4.
- rst asserted for one cycle while full with mem_ack=1 and insn_ready=1: the next cycle has count=0, insn=0, insn_pc=0, mem_adr=RESET_PC, and fetch restarts from RESET_PC.

Source files
------------

// File: rtl/instr_fetch.sv
// instr_fetch: owns the fetch PC, fetches over a valid/ack memory handshake and buffers
// {pc, insn} pairs in a small FIFO drained by decode; redirect flushes and restarts fetch.
module instr_fetch #(
  parameter int ADDR_W = 16,
  parameter int INSN_W = 64,
  parameter int DEPTH = 4,
  parameter int PC_STEP = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = 16'd0
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     mem_req,
  output logic [ADDR_W-1:0]        mem_adr,
  input  logic                     mem_ack,
  input  logic [INSN_W-1:0]        mem_rdata,
  input  logic                     redirect,
  input  logic [ADDR_W-1:0]        redirect_pc,
  output logic                     insn_valid,
  input  logic                     insn_ready,
  output logic [INSN_W-1:0]        insn,
  output logic [ADDR_W-1:0]        insn_pc,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [ADDR_W+INSN_W-1:0] fifo_q [DEPTH];
  logic [ADDR_W+INSN_W-1:0] head;
  logic push, pop;
  // Request and valid see only rst/redirect combinationally, never insn_ready.
  assign mem_req = !rst && !redirect && (cnt_q < CW'(DEPTH));
  assign insn_valid = !rst && !redirect && (cnt_q != '0);
  assign mem_adr = fetch_pc_q;
  assign push = mem_req && mem_ack;
  assign pop = insn_valid && insn_ready;
  assign head = fifo_q[rd_q];
  assign insn = insn_valid ? head[INSN_W-1:0] : '0;
  assign insn_pc = insn_valid ? head[ADDR_W+INSN_W-1:INSN_W] : '0;
  assign count = rst ? '0 : cnt_q;
  always_comb begin
    fetch_pc_d = redirect ? {redirect_pc[ADDR_W-1:2], 2'b00} :
                 push ? fetch_pc_q + ADDR_W'(PC_STEP) : fetch_pc_q;
    wr_d = redirect ? '0 : wr_q + PW'(push);
    rd_d = redirect ? '0 : rd_q + PW'(pop);
    cnt_d = redirect ? '0 : cnt_q + CW'(push) - CW'(pop);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  // Storage carries no reset; only entries below count are ever presented.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_q] <= {fetch_pc_q, mem_rdata};
  end
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: randomized and directed stimulus against a queue-based fetch model,
// with a separate monitor comparing every DUT cycle and every consumed instruction.
module tb_instr_fetch;
  logic clk, rst, mem_req, mem_ack, redirect, insn_valid, insn_ready;
  logic [15:0] mem_adr, redirect_pc, insn_pc;
  logic [63:0] mem_rdata, insn;
  logic [2:0] count;
  int n_chk = 0, n_pass = 0, m_cnt = 0;
  logic [15:0] m_pc = 16'h0;
  logic [79:0] exp_q[$];

  instr_fetch dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_adr(mem_adr), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .redirect(redirect), .redirect_pc(redirect_pc),
    .insn_valid(insn_valid), .insn_ready(insn_ready), .insn(insn), .insn_pc(insn_pc),
    .count(count)
  );

  function automatic logic [63:0] word(input logic [15:0] a);
    return {a ^ 16'hA5A5, a + 16'h1357, ~a, a[7:0], a[15:8]};
  endfunction

  assign mem_rdata = word(mem_adr);

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // One cycle of stimulus; the model advances at the clock edge from its own queue state.
  task automatic cyc(input logic r, input logic rd, input logic [15:0] rp,
                     input logic a, input logic y);
    bit pu, po;
    @(negedge clk);
    rst = r; redirect = rd; redirect_pc = rp; mem_ack = a; insn_ready = y;
    @(posedge clk);
    if (r) begin
      exp_q.delete(); m_cnt = 0; m_pc = 16'h0;
    end else if (rd) begin
      exp_q.delete(); m_cnt = 0; m_pc = rp & 16'hFFFC;
    end else begin
      pu = (m_cnt < 4) && a;
      po = (m_cnt > 0) && y;
      if (pu) begin
        exp_q.push_back({m_pc, word(m_pc)});
        m_pc = m_pc + 16'd4;
      end
      m_cnt = m_cnt + int'(pu) - int'(po);
    end
  endtask

  initial begin
    logic [79:0] e;
    @(posedge clk);
    forever begin
      @(negedge clk);
      #2;
      chk("insn_valid", 80'(insn_valid), 80'(!rst && !redirect && m_cnt != 0));
      chk("mem_req", 80'(mem_req), 80'(!rst && !redirect && m_cnt < 4));
      chk("count", 80'(count), rst ? 80'd0 : 80'(m_cnt));
      chk("sb_size", 80'(exp_q.size()), 80'(m_cnt));
      if (!rst) chk("mem_adr", 80'(mem_adr), 80'(m_pc));
      if (insn_valid && insn_ready) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL sb_pop: DUT consumed pc %0h but no entry expected", insn_pc);
        end else begin
          e = exp_q.pop_front();
          chk("insn_pc", 80'(insn_pc), 80'(e[79:64]));
          chk("insn", 80'(insn), 80'(e[63:0]));
        end
      end else if (!insn_valid) begin
        chk("idle_zero", {insn_pc, insn}, 80'd0);
      end
    end
  end

  initial begin
    rst = 1; redirect = 0; redirect_pc = 0; mem_ack = 0; insn_ready = 0;
    repeat (2) cyc(1, 0, 0, 0, 0);
    repeat (8) cyc(0, 0, 0, 1, 1);
    cyc(1, 0, 0, 0, 0);
    repeat (6) cyc(0, 0, 0, 1, 0);
    repeat (8) cyc(0, 0, 0, 1, 1);
    cyc(1, 0, 0, 0, 0);
    repeat (3) cyc(0, 0, 0, 1, 0);
    cyc(0, 1, 16'h0102, 1, 1);
    repeat (5) cyc(0, 0, 0, 1, 1);
    cyc(0, 1, 16'hFFF8, 1, 1);
    repeat (6) cyc(0, 0, 0, 1, 1);
    for (int i = 0; i < 2000; i++)
      cyc(0, $urandom_range(0, 63) == 0, 16'($urandom),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    repeat (5) cyc(0, 0, 0, 1, 0);
    cyc(1, 0, 0, 1, 1);
    repeat (6) cyc(0, 0, 0, 1, 1);
    @(negedge clk);
    #3;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
